// File: rtl/processor_defines.sv
// ALU operation codes shared by the processor datapath and by the tools that
// generate instruction streams for it.
package processor_defines;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_NOP  = 5'd10;

endpackage

// File: rtl/rv32i_enc_pkg.sv
// RV32I R-type encoding constants, field layout and loader state type.
package rv32i_enc_pkg;

  localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
  localparam logic [6:0]  F7_BASE   = 7'b0000000;
  localparam logic [6:0]  F7_ALT    = 7'b0100000;
  localparam logic [31:0] INST_NOP  = 32'h0000_0013;  // addi x0, x0, 0

  // Declared MSB first so the struct packs straight into an instruction word.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_fields_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } enc_state_t;

endpackage

// File: rtl/encode_reg_inst_loader_if.sv
// Request and IMEM-write bus of the R-type instruction loader.
//   in_*   : ALU request (valid/ready handshake)
//   imem_* : instruction memory write port (we/ready handshake)
// slave  = loader side, master = request source / IMEM side.
interface encode_reg_inst_loader_if #(
  parameter int ADDR_W = 32
) ();

  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_alu_control;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  in_valid, in_alu_control, in_rs1, in_rs2, in_rd, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_alu_control, in_rs1, in_rs2, in_rd, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/encode_reg_inst_loader_sync_fifo.sv
// Single-clock FIFO with full/empty flags.
//   push/wdata : write port (ignored when full)
//   pop        : read advance (ignored when empty)
//   rdata      : current head entry, valid while !empty
// DEPTH must be a power of two, >= 2.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // NOTE: storage is deliberately not reset; only the pointers define which
  // entries are meaningful, so resetting the array would just cost flops.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rdata = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/encode_reg_inst_loader.sv
// Encodes R-type ALU requests into RV32I instruction words and streams them
// into IMEM at consecutive word addresses starting at base_addr.
//   start/base_addr/num_inst : begin a load of num_inst words (IDLE only)
//   bus (slave)              : request handshake in, IMEM write handshake out
//   busy                     : not IDLE
//   done                     : one-cycle pulse after the last IMEM write
//   err                      : sticky, an unencodable alu_control was seen
module encode_reg_inst_loader
  import rv32i_enc_pkg::*;
  import processor_defines::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [CNT_W-1:0]        num_inst,
  encode_reg_inst_loader_if.slave bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef struct packed {
    logic        ok;
    logic [31:0] word;
  } enc_t;

  function automatic enc_t encode_rtype(input logic [4:0] alu_control,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2,
                                        input logic [4:0] rd);
    rtype_fields_t f;
    enc_t          r;
    f.funct7 = F7_BASE;
    f.rs2    = rs2;
    f.rs1    = rs1;
    f.funct3 = 3'b000;
    f.rd     = rd;
    f.opcode = OPC_RTYPE;
    r.ok     = 1'b1;
    case (alu_control)
      ALU_ADD:  f.funct3 = 3'b000;
      ALU_SUB:  f.funct7 = F7_ALT;
      ALU_SLL:  f.funct3 = 3'b001;
      ALU_SLT:  f.funct3 = 3'b010;
      ALU_SLTU: f.funct3 = 3'b011;
      ALU_XOR:  f.funct3 = 3'b100;
      ALU_SRL:  f.funct3 = 3'b101;
      ALU_SRA:  begin f.funct3 = 3'b101; f.funct7 = F7_ALT; end
      ALU_OR:   f.funct3 = 3'b110;
      ALU_AND:  f.funct3 = 3'b111;
      default:  r.ok = 1'b0;
    endcase
    if (r.ok) r.word = f;
    else      r.word = INST_NOP;
    return r;
  endfunction

  enc_state_t        state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  wr_cnt, wr_cnt_nxt;
  logic [CNT_W-1:0]  acc_cnt;
  logic              load_go;
  logic              in_ready;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [31:0]       fifo_head;
  enc_t              enc;

  assign enc = encode_rtype(bus.in_alu_control, bus.in_rs1, bus.in_rs2, bus.in_rd);

  assign load_go    = (state == ST_IDLE) && start;
  assign in_ready   = (state == ST_LOAD) && !fifo_full && (acc_cnt < num_q);
  assign push       = bus.in_valid && in_ready;
  assign pop        = !fifo_empty && bus.imem_ready;
  assign wr_cnt_nxt = wr_cnt + CNT_W'(pop);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (enc.word),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: state_nxt gets a default before the case so no path through the
  // block leaves it unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (num_inst == '0) ? ST_DONE : ST_LOAD;
      // Looks at the post-handshake count so done follows the last write
      // by exactly one cycle.
      ST_LOAD: if (wr_cnt_nxt == num_q) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      base_q  <= '0;
      num_q   <= '0;
      wr_cnt  <= '0;
      acc_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_go) begin
        base_q  <= base_addr & ~ADDR_W'(3);
        num_q   <= num_inst;
        wr_cnt  <= '0;
        acc_cnt <= '0;
        err     <= 1'b0;
      end else begin
        if (push) acc_cnt <= acc_cnt + CNT_W'(1);
        if (pop)  wr_cnt  <= wr_cnt_nxt;
        if (push && !enc.ok) err <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = !fifo_empty;
  // Head is masked while empty so the unreset storage never leaks out.
  assign bus.imem_wdata = fifo_empty ? 32'h0 : fifo_head;
  assign bus.imem_addr  = base_q + (ADDR_W'(wr_cnt) << 2);
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_DONE);

endmodule

// File: doc/encode_reg_inst_loader.md
# encode_reg_inst_loader

Encodes R-type ALU operation requests (`alu_control`, `rs1`, `rs2`, `rd`) into 32-bit RV32I instruction words and writes them into instruction memory at consecutive word addresses. It is the inverse of the R-type register-instruction decode path. It sits between the test/boot program source and the IMEM write port. A small FIFO decouples request acceptance from IMEM back-pressure.

## Interface
Parameters:
- `ADDR_W`, 32: IMEM byte-address width.
- `FIFO_DEPTH`, 4: encoded-word buffer depth (power of 2, ≥2).
- `CNT_W`, 16: width of the instruction count.

Ports:
- `clk`  in  1  clock; all logic rises on posedge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- `base_addr`  in  ADDR_W  first IMEM byte address; sampled on `start`; bits [1:0] are ignored and forced to 0.
- `num_inst`  in  CNT_W  number of instructions to load; sampled on `start`.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_alu_control`  in  5  operation code, using the `processor_defines` ALU codes.
- `in_rs1`, `in_rs2`, `in_rd`  in  5 each  register indices.
- `imem_we`  out  1  write request.
- `imem_ready`  in  1  IMEM accepts the write this cycle.
- `imem_addr`  out  ADDR_W  write byte address.
- `imem_wdata`  out  32  encoded instruction.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  one-cycle pulse when the load completes.
- `err`  out  1  sticky; set on any unencodable `alu_control`; cleared on `start`.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE → LOAD on `start`. If `num_inst == 0`, IDLE → DONE instead.
- LOAD → DONE when `wr_cnt == num_inst`.
- DONE → IDLE after exactly one cycle. `done` is high in DONE.
- `start` outside IDLE is ignored.
- `in_ready = (state == LOAD) && !fifo_full && (acc_cnt < num_inst)`.
- Encoding: [6:0] = 7'b0110011; [11:7] = rd; [14:12] = funct3; [19:15] = rs1; [24:20] = rs2; [31:25] = funct7.
- funct3/funct7 mapping:
  - ADD 000/0000000; SUB 000/0100000
  - SLL 001; SLT 010; SLTU 011; XOR 100
  - SRL 101/0000000; SRA 101/0100000
  - OR 110; AND 111
  - All operations not listed with a funct7 use funct7 0000000.
- Any other `alu_control` value, including ALU_NOP, writes the canonical NOP 32'h00000013 and sets `err`. The word still counts toward `num_inst`.
- Encoding is combinational at the FIFO input. The FIFO entry holds the 32-bit word only.
- `imem_we = !fifo_empty`. `imem_wdata` is the FIFO head. `imem_addr = base_addr + 4*wr_cnt`.
- On `imem_we && imem_ready`: pop the FIFO and increment `wr_cnt`.
- Address arithmetic wraps modulo 2^ADDR_W. No overflow flag.

## Timing
- Reset values: `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `busy` 0, `done` 0, `err` 0. Counters are 0, FIFO is empty, state is IDLE.
- Latency: with an empty FIFO, a request accepted in cycle N drives `imem_we` in cycle N+1.
- Throughput: 1 word/cycle when `imem_ready` is held high.
- Simultaneous push and pop on a full FIFO is not possible, because `in_ready` is low when full. Simultaneous push and pop on a non-full FIFO keeps the occupancy unchanged.
- `imem_wdata` and `imem_addr` are stable while `imem_we && !imem_ready`.
- `done` asserts the cycle after the final IMEM handshake.
- Reset asserted mid-load: all state clears immediately. Un-written FIFO words are discarded.

## Structure
- Shared package `rv32i_enc_pkg` holds:
  - `OPC_RTYPE`, `F7_BASE`, `F7_ALT`, `INST_NOP`
  - `rtype_fields_t` (packed struct matching the bit layout)
  - `enc_state_t` enum
- ALU codes stay in `processor_defines.sv`.
- One sub-module: `sync_fifo` (parameterised width/depth; full/empty flags; async active-low reset).
- Encode function is local to this block.

## Test plan
- `start`, `base_addr` = 0x100, `num_inst` = 1, request ADD x3,x1,x2 → single write at 0x100 with data 0x002081B3, then `done` pulse, `err` = 0.
- Three back-to-back requests SUB x5,x6,x7; SRA x31,x30,x29; AND x0,x0,x0 with `imem_ready` = 1 → writes 0x407302B3 @0x200, 0x41DF5FB3 @0x204, 0x00007033 @0x208 on consecutive cycles.
- `imem_ready` held low for 10 cycles with `FIFO_DEPTH` = 4 → `in_ready` drops after 4 accepts. `imem_addr`/`imem_wdata` remain stable. All words are written in order after release.
- Request with ALU_NOP → 0x00000013 written and `err` = 1. A subsequent `start` clears `err`.
- `num_inst` = 0 → `done` pulses the cycle after `start`, no `imem_we`. `start` pulsed during LOAD is ignored.
- `rst_n` low after 2 of 5 words written → all outputs return to reset values immediately. A new load starts cleanly from its new `base_addr`.
